// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: NCH square waves plus wrap ticks, divisors
// loaded through a shadow register. Optional global phase-align port via CLKDIV_SYNC_EN.
module clk_div_multi #(
    parameter int NCH         = 4,
    parameter int WIDTH       = 12,
    parameter int DEFAULT_DIV = 2499,
    localparam int SELW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [NCH-1:0]   en,
    input  logic             wr,
    input  logic [SELW-1:0]  wr_sel,
    input  logic [WIDTH-1:0] wr_div,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync,
`endif
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   pending
);

    logic [WIDTH-1:0] cnt_q [NCH];
    logic [WIDTH-1:0] cnt_d [NCH];
    logic [WIDTH-1:0] div_q [NCH];
    logic [WIDTH-1:0] div_d [NCH];
    logic [WIDTH-1:0] shd_q [NCH];
    logic [WIDTH-1:0] shd_d [NCH];
    logic [NCH-1:0]   pend_q, pend_d;
    logic [NCH-1:0]   clk_q, clk_d;
    logic [NCH-1:0]   tick_q, tick_d;
    logic             sync_w;

`ifdef CLKDIV_SYNC_EN
    assign sync_w = sync;
`else
    assign sync_w = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            // NOTE: every next-state signal gets its hold value first so no path infers a latch.
            cnt_d[i]  = cnt_q[i];
            div_d[i]  = div_q[i];
            shd_d[i]  = shd_q[i];
            pend_d[i] = pend_q[i];
            clk_d[i]  = clk_q[i];
            tick_d[i] = 1'b0;

            if (sync_w) begin
                cnt_d[i] = '0;
                clk_d[i] = 1'b0;
                if (pend_q[i]) begin
                    div_d[i]  = shd_q[i];
                    pend_d[i] = 1'b0;
                end
            end else if (en[i]) begin
                if (cnt_q[i] == div_q[i]) begin
                    cnt_d[i]  = '0;
                    clk_d[i]  = ~clk_q[i];
                    tick_d[i] = 1'b1;
                    if (pend_q[i]) begin
                        div_d[i]  = shd_q[i];
                        pend_d[i] = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + WIDTH'(1);
                end
            end else if (pend_q[i]) begin
                // A stopped channel has no wrap to wait for, so the shadow lands at once.
                div_d[i]  = shd_q[i];
                cnt_d[i]  = '0;
                pend_d[i] = 1'b0;
            end

            // A write after the apply decision keeps the new value pending for the next wrap.
            if (wr && (wr_sel == SELW'(i))) begin
                shd_d[i]  = wr_div;
                pend_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= WIDTH'(DEFAULT_DIV);
                shd_q[i] <= WIDTH'(DEFAULT_DIV);
            end
            pend_q <= '0;
            clk_q  <= '0;
            tick_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all channels update together.
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
                div_q[i] <= div_d[i];
                shd_q[i] <= shd_d[i];
            end
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;
    assign pending = pend_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi; NCH=5 so out-of-range selects 5..7 are encodable.
module tb_clk_div_multi;

    localparam int NCH         = 5;
    localparam int WIDTH       = 12;
    localparam int DEFAULT_DIV = 2499;
    localparam int SELW        = 3;

    logic             CLOCK = 1'b0;
    logic             RESET = 1'b1;
    logic [NCH-1:0]   en = '0;
    logic             wr = 1'b0;
    logic [SELW-1:0]  wr_sel = '0;
    logic [WIDTH-1:0] wr_div = '0;
`ifdef CLKDIV_SYNC_EN
    logic             sync = 1'b0;
`endif
    logic [NCH-1:0]   clk_out, tick, pending;

    int checks   = 0;
    int failures = 0;

    clk_div_multi #(.NCH(NCH), .WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) dut (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .en     (en),
        .wr     (wr),
        .wr_sel (wr_sel),
        .wr_div (wr_div),
`ifdef CLKDIV_SYNC_EN
        .sync   (sync),
`endif
        .clk_out(clk_out),
        .tick   (tick),
        .pending(pending)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic write_pulse(input int sel, input int div);
        wr     = 1'b1;
        wr_sel = SELW'(sel);
        wr_div = WIDTH'(div);
        step();
        wr     = 1'b0;
    endtask

    // Steps until tick[ch] is seen; n is the edge count, or bound if it never came.
    task automatic wait_tick(input int ch, input int bound, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick[ch] && n < bound);
    endtask

    initial begin
        int n;
        int first [3];

        repeat (2) step();
        check("reset_clk_out", 32'(clk_out), 0);
        check("reset_tick", 32'(tick), 0);
        check("reset_pending", 32'(pending), 0);

        RESET = 1'b0;
        en    = '1;
        wait_tick(0, 3000, n);
        check("first_tick_2500", n, 2500);
        check("first_tick_all", 32'(tick), 32'h1f);
        check("clk_out_high", 32'(clk_out), 32'h1f);
        wait_tick(0, 3000, n);
        check("second_tick_2500", n, 2500);
        check("clk_out_low", 32'(clk_out), 0);
        check("pending_idle", 32'(pending), 0);

        // Channel 1 reprogrammed mid-count: old period finishes first.
        repeat (100) step();
        write_pulse(1, 4);
        check("wr_pending_ch1", 32'(pending), 32'h02);
        wait_tick(1, 3000, n);
        check("ch1_old_period_tail", n, 2399);
        check("ch1_pending_clear", 32'(pending[1]), 0);
        check("ch1_clk_after_wrap", 32'(clk_out[1]), 1);
        wait_tick(1, 50, n);
        check("ch1_new_tick_5", n, 5);
        check("ch1_clk_half1", 32'(clk_out[1]), 0);
        wait_tick(1, 50, n);
        check("ch1_new_tick_5b", n, 5);
        check("ch1_clk_half2", 32'(clk_out[1]), 1);

        // Channel 2 stopped, div=0 applied without a wrap, then CLOCK/2.
        en = 5'b11011;
        write_pulse(2, 0);
        check("ch2_pending_set", 32'(pending[2]), 1);
        check("ch2_stopped_tick", 32'(tick[2]), 0);
        step();
        check("ch2_applied_stopped", 32'(pending[2]), 0);
        check("ch2_clk_held", 32'(clk_out[2]), 1);
        en = '1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("ch2_div0_tick", 32'(tick[2]), 1);
            check("ch2_div0_clk", 32'(clk_out[2]), 32'(k % 2 == 0));
        end

        // Channel 0: div 5, then writes 7 and 3; the 3 arrives on the wrap edge.
        en = 5'b11110;
        write_pulse(0, 5);
        check("ch0_pend_stopped", 32'(pending[0]), 1);
        step();
        check("ch0_applied_stopped", 32'(pending[0]), 0);
        en = '1;
        step();
        write_pulse(0, 7);
        repeat (3) step();
        check("ch0_no_tick_yet", 32'(tick[0]), 0);
        write_pulse(0, 3);
        check("ch0_wrap_tick", 32'(tick[0]), 1);
        check("ch0_wrap_pend_kept", 32'(pending[0]), 1);
        check("ch0_wrap_clk", 32'(clk_out[0]), 0);
        wait_tick(0, 50, n);
        check("ch0_period_div7", n, 8);
        check("ch0_pend_cleared", 32'(pending[0]), 0);
        check("ch0_clk_div7", 32'(clk_out[0]), 1);
        wait_tick(0, 50, n);
        check("ch0_period_div3", n, 4);
        check("ch0_clk_div3", 32'(clk_out[0]), 0);

        // Out-of-range selects are ignored.
        write_pulse(5, 1);
        check("sel5_ignored", 32'(pending), 0);
        write_pulse(7, 1);
        check("sel7_ignored", 32'(pending), 0);
        write_pulse(3, 100);
        check("sel3_pending", 32'(pending), 32'h08);

        // Asynchronous reset mid-count.
        RESET = 1'b1;
        #1;
        check("async_rst_clk_out", 32'(clk_out), 0);
        check("async_rst_tick", 32'(tick), 0);
        check("async_rst_pending", 32'(pending), 0);
        step();
        RESET = 1'b0;
        en    = '1;
        wait_tick(1, 3000, n);
        check("rst_default_div_ch1", n, 2500);
        check("rst_default_all_tick", 32'(tick), 32'h1f);
        check("rst_pending_lost", 32'(pending), 0);

`ifdef CLKDIV_SYNC_EN
        en = '0;
        write_pulse(0, 2);
        write_pulse(1, 5);
        write_pulse(2, 9);
        step();
        check("sync_setup_pending", 32'(pending), 0);
        en = '1;
        repeat (7) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync_clk_out", 32'(clk_out), 0);
        check("sync_tick", 32'(tick), 0);
        first = '{0, 0, 0};
        for (int k = 1; k <= 12; k++) begin
            step();
            for (int c = 0; c < 3; c++)
                if (tick[c] && first[c] == 0) first[c] = k;
        end
        check("sync_first_tick_ch0", first[0], 3);
        check("sync_first_tick_ch1", first[1], 6);
        check("sync_first_tick_ch2", first[2], 10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
